operand_fetch: RTL

Pipeline stage directly downstream of the read-address driver: accepts a pair of register read addresses per cycle, reads two operands from an internal 2-read/1-write register file, and presents them, registered, to the execute stage. It owns the architectural register storage, accepts writeback traffic on a dedicated write port, and forwards same-cycle writes to reads. A valid/ready handshake on both sides lets execute back-pressure the address driver.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/reg_file_2r1w.sv | 60 ++++++
 rtl/operand_fetch.sv | 103 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, zero-register behaviour,
// and the encoding of the operand-fetch output register occupancy.
package pipeline_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_ADDR_WIDTH = 5;
   localparam bit DEFAULT_ZERO_REG   = 1'b1;

   // Register 0 is the hard-wired zero register when ZERO_REG is enabled
   localparam int REG_ZERO_ADDR = 0;

   // Width of the accepted-request counter exposed on the debug output
   localparam int COUNT_WIDTH = 4;

   // Occupancy of the one-entry output register
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with asynchronous clear, an optional
// hard-wired zero register, and write-to-read bypass on both read ports.
module reg_file_2r1w
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter bit ZERO_REG   = DEFAULT_ZERO_REG
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic [ADDR_WIDTH-1:0] i_rdaddr_A,
   input  logic [ADDR_WIDTH-1:0] i_rdaddr_B,
   output logic [DATA_WIDTH-1:0] o_rddata_A,
   output logic [DATA_WIDTH-1:0] o_rddata_B,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wraddr,
   input  logic [DATA_WIDTH-1:0] i_wrdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO_ADDR);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  wr_allowed;

   assign wr_allowed = i_wr_en && !(ZERO_REG && (i_wraddr == ZERO_ADDR));

   // Storage: cleared on reset, otherwise written by the writeback port
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_allowed) begin
         mem[i_wraddr] <= i_wrdata;
      end
   end

   // Port A read: zero register first, then same-cycle write bypass, then storage
   always_comb begin
      o_rddata_A = mem[i_rdaddr_A];
      if (ZERO_REG && (i_rdaddr_A == ZERO_ADDR)) begin
         o_rddata_A = '0;
      end else if (i_wr_en && (i_wraddr == i_rdaddr_A)) begin
         o_rddata_A = i_wrdata;
      end
   end

   // Port B read: identical priority to port A
   always_comb begin
      o_rddata_B = mem[i_rdaddr_B];
      if (ZERO_REG && (i_rdaddr_B == ZERO_ADDR)) begin
         o_rddata_B = '0;
      end else if (i_wr_en && (i_wraddr == i_rdaddr_B)) begin
         o_rddata_B = i_wrdata;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts register address pairs, reads the register
// file, and holds the operands in a one-entry output register towards execute.
module operand_fetch
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter bit ZERO_REG   = DEFAULT_ZERO_REG
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic [ADDR_WIDTH-1:0] i_rdaddr_A,
   input  logic [ADDR_WIDTH-1:0] i_rdaddr_B,
   input  logic                  i_rd_valid,
   output logic                  o_rd_ready,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wraddr,
   input  logic [DATA_WIDTH-1:0] i_wrdata,
   output logic [DATA_WIDTH-1:0] o_opA,
   output logic [DATA_WIDTH-1:0] o_opB,
   output logic                  o_op_valid,
   input  logic                  i_op_ready,
   output logic [3:0]            o_count_HEX0
);

   fetch_state_t           state;
   fetch_state_t           next_state;
   logic [DATA_WIDTH-1:0]  rd_data_A;
   logic [DATA_WIDTH-1:0]  rd_data_B;
   logic [COUNT_WIDTH-1:0] accept_count;
   logic                   accept;

   reg_file_2r1w #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_reg_file (
      .i_CLK      (i_CLK),
      .i_RST      (i_RST),
      .i_rdaddr_A (i_rdaddr_A),
      .i_rdaddr_B (i_rdaddr_B),
      .o_rddata_A (rd_data_A),
      .o_rddata_B (rd_data_B),
      .i_wr_en    (i_wr_en),
      .i_wraddr   (i_wraddr),
      .i_wrdata   (i_wrdata)
   );

   assign o_op_valid   = (state == ST_FULL);
   assign o_rd_ready   = !o_op_valid || i_op_ready;
   assign accept       = i_rd_valid && o_rd_ready;
   assign o_count_HEX0 = accept_count;

   // Output register occupancy
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state <= ST_EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // Next occupancy: any accept fills; a consume with no accept drains
   always_comb begin
      next_state = state;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               next_state = ST_FULL;
            end
         end
         ST_FULL: begin
            if (accept) begin
               next_state = ST_FULL;
            end else if (i_op_ready) begin
               next_state = ST_EMPTY;
            end
         end
         default: next_state = ST_EMPTY;
      endcase
   end

   // Operands are snapshotted only on accept, so later writes cannot disturb held values
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         o_opA <= '0;
         o_opB <= '0;
      end else if (accept) begin
         o_opA <= rd_data_A;
         o_opB <= rd_data_B;
      end
   end

   // Accepted-request counter, free-running modulo 16
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         accept_count <= '0;
      end else if (accept) begin
         accept_count <= accept_count + 1'b1;
      end
   end

endmodule
